soft_start_ctrl: RTL and testbench
==================================

Name: soft_start_ctrl

Overview:
Supervisory sequencer in front of the open-loop, no-soft-start PWM core (200 MHz domain). It gates the PWM enable, ramps duty from 0 to the switch-selected target at a fixed slew rate, and slew-limits later target changes. It applies dead-time settings only at PWM period boundaries and forces a latched safe shutdown on fault. Its outputs drive the PWM core's enable, duty and dead-time inputs directly.

Parameters:
DUTY_W, 8, duty word width
DT_W, 4, dead-time word width
RAMP_DIV, 1000, clk cycles per 1-LSB duty step (>=2)
DUTY_MAX, 242, duty clamp ceiling
MIN_DT, 2, dead-time floor applied to both edges
DT_SAFE, 15, dead time forced in FAULT and after reset

Ports:
clk  in  1  system clock (200 MHz PLL output)
rst  in  1  synchronous, active-high reset
i_enable  in  1  run request (level)
i_fault  in  1  fault/overcurrent (level, already synchronised)
i_duty_target  in  DUTY_W  requested duty
i_dt1  in  DT_W  requested dead time, c1 edge
i_dt2  in  DT_W  requested dead time, c2 edge
i_period_start  in  1  one-cycle strobe from PWM core at period start
o_enable  out  1  PWM core enable
o_duty  out  DUTY_W  duty to PWM core
o_dt1  out  DT_W  applied dead time 1
o_dt2  out  DT_W  applied dead time 2
o_state  out  2  IDLE=0, RAMP=1, RUN=2, FAULT=3
o_ramp_done  out  1  high while in RUN

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, o_enable=0, o_duty=0, o_dt1=o_dt2=DT_SAFE, o_ramp_done=0, prescaler=0.
- tgt = min(i_duty_target, DUTY_MAX), evaluated combinationally every cycle.
- dt_clamp(x) = max(x, MIN_DT).
- Prescaler:
  - Counts 0..RAMP_DIV-1 only in RAMP and RUN; held at 0 in IDLE and FAULT.
  - tick = 1 in the cycle where count == RAMP_DIV-1; count wraps to 0 in that cycle.
- Priority per cycle: fault > enable-drop > state action.
- IDLE:
  - o_enable=0, o_duty=0.
  - If i_enable && !i_fault: next cycle state=RAMP, o_enable=1, o_duty=0, o_dt1/o_dt2=dt_clamp(inputs). Latency from i_enable to o_enable is 1 cycle.
- RAMP:
  - On tick: o_duty += 1 if o_duty < tgt; o_duty -= 1 if o_duty > tgt.
  - When o_duty == tgt at a clock edge: next state RUN, o_ramp_done=1.
  - If tgt == 0 on entry: RUN one cycle after entry, o_duty stays 0, o_enable stays 1.
- RUN:
  - On tick: step o_duty by ±1 toward tgt; no step if equal. A target change never produces a jump larger than 1 LSB per RAMP_DIV cycles.
- Dead-time updates:
  - In RAMP/RUN, o_dt1/o_dt2 load dt_clamp(i_dt1/i_dt2) only in cycles with i_period_start=1.
  - Otherwise they hold, even if the inputs change.
  - tick and i_period_start are independent; both are honoured in the same cycle.
- Enable drop: i_enable=0 in RAMP/RUN gives next cycle IDLE, o_enable=0, o_duty=0, o_ramp_done=0. This is a hard stop with no ramp-down. Dead time holds its last value.
- FAULT entry:
  - i_fault=1 in any state gives next cycle FAULT, o_enable=0, o_duty=0, o_dt1=o_dt2=DT_SAFE, o_ramp_done=0.
  - Entry happens even if i_enable=1.
- FAULT exit:
  - FAULT is latched. Exit to IDLE only when i_fault=0 && i_enable=0 in the same cycle (operator re-arm).
  - Fault clearing while i_enable stays high keeps FAULT.
- Reset mid-ramp: returns to reset values next cycle, with no enable glitch.
- o_duty never exceeds DUTY_MAX. Increment/decrement never wraps; the comparison to tgt guarantees this.

Decomposition:
- Package smps_ctrl_pkg: state enum (IDLE/RAMP/RUN/FAULT, 2-bit), DUTY_W/DT_W defaults, DT_SAFE, MIN_DT. This package is shared with the future closed-loop controller.
- Sub-module ramp_prescaler (parameter RAMP_DIV; ports clk, rst, i_run, o_tick).
- FSM, slew logic and dead-time latch stay in soft_start_ctrl.

Test Plan:
(Bench overrides RAMP_DIV=4.)
1. Reset, then i_enable=1, tgt=5 -> o_enable=1 one cycle later. o_duty steps 0→5, one LSB every 4 cycles. o_state=2 and o_ramp_done=1 the cycle after o_duty==5.
2. In RUN at duty 5, change i_duty_target to 2 -> o_duty 4,3,2 at 4-cycle spacing. i_duty_target=255 -> ramps up and settles at 242.
3. In RUN, change i_dt1=0, i_dt2=9 with no strobe for 20 cycles -> o_dt unchanged. Pulse i_period_start -> o_dt1=2, o_dt2=9 next cycle.
4. Mid-ramp (duty 3) pulse i_fault for 1 cycle -> FAULT next cycle, o_enable=0, o_duty=0, o_dt=15. State stays FAULT while i_enable=1. Drop i_enable -> IDLE. Raise i_enable -> new ramp from 0.
5. i_fault and i_enable rising in the same IDLE cycle -> FAULT; o_enable never asserts.
6. rst asserted in RUN at duty 7 -> all outputs at reset values next cycle. tgt=0 enable -> RAMP then RUN with o_duty=0, o_enable=1.

Source files
------------

// File: rtl/smps_ctrl_pkg.sv
// Shared definitions for the SMPS supervisory controllers (soft-start and future closed loop).
package smps_ctrl_pkg;

    localparam int unsigned DUTY_W_DFLT  = 8;
    localparam int unsigned DT_W_DFLT    = 4;
    localparam int unsigned DT_SAFE_DFLT = 15;
    localparam int unsigned MIN_DT_DFLT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/ramp_prescaler.sv
// Slew-rate prescaler: one-cycle tick every RAMP_DIV cycles while running, cleared otherwise.
module ramp_prescaler #(
    parameter int unsigned RAMP_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_tick
);

    localparam int unsigned CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_tick = i_run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/soft_start_ctrl.sv
// Soft-start sequencer for the open-loop PWM core: enable gating, duty slew limiting,
// period-aligned dead-time loading and latched fault shutdown.
module soft_start_ctrl
    import smps_ctrl_pkg::*;
#(
    parameter int unsigned DUTY_W   = DUTY_W_DFLT,
    parameter int unsigned DT_W     = DT_W_DFLT,
    parameter int unsigned RAMP_DIV = 1000,
    parameter int unsigned DUTY_MAX = 242,
    parameter int unsigned MIN_DT   = MIN_DT_DFLT,
    parameter int unsigned DT_SAFE  = DT_SAFE_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_fault,
    input  logic [DUTY_W-1:0] i_duty_target,
    input  logic [DT_W-1:0]   i_dt1,
    input  logic [DT_W-1:0]   i_dt2,
    input  logic              i_period_start,
    output logic              o_enable,
    output logic [DUTY_W-1:0] o_duty,
    output logic [DT_W-1:0]   o_dt1,
    output logic [DT_W-1:0]   o_dt2,
    output logic [1:0]        o_state,
    output logic              o_ramp_done
);

    localparam logic [DUTY_W-1:0] DUTY_CEIL = DUTY_W'(DUTY_MAX);
    localparam logic [DT_W-1:0]   DT_FLOOR  = DT_W'(MIN_DT);
    localparam logic [DT_W-1:0]   DT_SAFE_V = DT_W'(DT_SAFE);

    ctrl_state_e       state_q;
    ctrl_state_e       state_d;
    logic              en_d;
    logic [DUTY_W-1:0] duty_d;
    logic [DT_W-1:0]   dt1_d;
    logic [DT_W-1:0]   dt2_d;
    logic              done_d;
    logic [DUTY_W-1:0] tgt_c;
    logic              running;
    logic              tick;

    function automatic logic [DT_W-1:0] dt_clamp(input logic [DT_W-1:0] x);
        return (x < DT_FLOOR) ? DT_FLOOR : x;
    endfunction

    assign tgt_c   = (i_duty_target > DUTY_CEIL) ? DUTY_CEIL : i_duty_target;
    assign running = (state_q == RAMP) || (state_q == RUN);

    ramp_prescaler #(
        .RAMP_DIV (RAMP_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_run  (running),
        .o_tick (tick)
    );

    // State register together with the registered PWM-core drive
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            o_enable    <= 1'b0;
            o_duty      <= '0;
            o_dt1       <= DT_SAFE_V;
            o_dt2       <= DT_SAFE_V;
            o_ramp_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_enable    <= en_d;
            o_duty      <= duty_d;
            o_dt1       <= dt1_d;
            o_dt2       <= dt2_d;
            o_ramp_done <= done_d;
        end
    end

    assign o_state = state_q;

    // Next state: fault beats enable-drop beats the per-state action
    always_comb begin
        state_d = state_q;
        if (i_fault) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE:    if (i_enable) state_d = RAMP;
                RAMP: begin
                    if (!i_enable)            state_d = IDLE;
                    else if (o_duty == tgt_c) state_d = RUN;
                end
                RUN:     if (!i_enable) state_d = IDLE;
                FAULT:   if (!i_enable) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next output values; dead time holds unless explicitly reloaded
    always_comb begin
        en_d   = 1'b0;
        duty_d = '0;
        dt1_d  = o_dt1;
        dt2_d  = o_dt2;
        done_d = 1'b0;
        if (i_fault) begin
            dt1_d = DT_SAFE_V;
            dt2_d = DT_SAFE_V;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_enable) begin
                        en_d  = 1'b1;
                        dt1_d = dt_clamp(i_dt1);
                        dt2_d = dt_clamp(i_dt2);
                    end
                end
                RAMP, RUN: begin
                    if (i_enable) begin
                        en_d   = 1'b1;
                        duty_d = o_duty;
                        if (tick) begin
                            if (o_duty < tgt_c)      duty_d = o_duty + DUTY_W'(1);
                            else if (o_duty > tgt_c) duty_d = o_duty - DUTY_W'(1);
                        end
                        if (i_period_start) begin
                            dt1_d = dt_clamp(i_dt1);
                            dt2_d = dt_clamp(i_dt2);
                        end
                        done_d = (state_q == RUN) || (o_duty == tgt_c);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_soft_start_ctrl.sv
// Self-checking bench for soft_start_ctrl: directed scenarios plus randomized traffic vs a cycle model.
module tb_soft_start_ctrl;

    localparam int RDIV = 4;
    localparam int DMAX = 242;

    logic       clk = 1'b0;
    logic       rst, en, fault, ps;
    logic [7:0] tgt;
    logic [3:0] dt1, dt2;
    logic       o_enable, o_ramp_done;
    logic [7:0] o_duty;
    logic [3:0] o_dt1, o_dt2;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0=IDLE 1=RAMP 2=RUN 3=FAULT; m_age counts cycles spent running
    int m_state = 0, m_en = 0, m_duty = 0, m_dt1 = 15, m_dt2 = 15, m_done = 0, m_age = 0;

    always #5 clk = ~clk;

    soft_start_ctrl #(
        .RAMP_DIV (RDIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (en),
        .i_fault        (fault),
        .i_duty_target  (tgt),
        .i_dt1          (dt1),
        .i_dt2          (dt2),
        .i_period_start (ps),
        .o_enable       (o_enable),
        .o_duty         (o_duty),
        .o_dt1          (o_dt1),
        .o_dt2          (o_dt2),
        .o_state        (o_state),
        .o_ramp_done    (o_ramp_done)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int dtc(input int x);
        return (x < 2) ? 2 : x;
    endfunction

    task automatic model_edge();
        int  t;
        bit  run_now;
        bit  tk;
        t       = (int'(tgt) > DMAX) ? DMAX : int'(tgt);
        run_now = (m_state == 1) || (m_state == 2);
        tk      = run_now && ((m_age % RDIV) == RDIV - 1);
        if (rst) begin
            m_state = 0; m_en = 0; m_duty = 0; m_dt1 = 15; m_dt2 = 15; m_done = 0;
        end else if (fault) begin
            m_state = 3; m_en = 0; m_duty = 0; m_dt1 = 15; m_dt2 = 15; m_done = 0;
        end else if (m_state == 0) begin
            if (en) begin
                m_state = 1; m_en = 1; m_duty = 0; m_dt1 = dtc(int'(dt1)); m_dt2 = dtc(int'(dt2));
            end
        end else if (m_state == 3) begin
            if (!en) m_state = 0;
        end else if (!en) begin
            m_state = 0; m_en = 0; m_duty = 0; m_done = 0;
        end else begin
            if (m_state == 1 && m_duty == t) m_state = 2;
            m_done = (m_state == 2) ? 1 : 0;
            if (tk && m_duty < t) m_duty = m_duty + 1;
            else if (tk && m_duty > t) m_duty = m_duty - 1;
            if (ps) begin
                m_dt1 = dtc(int'(dt1));
                m_dt2 = dtc(int'(dt2));
            end
        end
        m_age = (!rst && run_now) ? m_age + 1 : 0;
    endtask

    task automatic compare_model();
        check("model_state",  int'(o_state),     m_state);
        check("model_enable", int'(o_enable),    m_en);
        check("model_duty",   int'(o_duty),      m_duty);
        check("model_dt1",    int'(o_dt1),       m_dt1);
        check("model_dt2",    int'(o_dt2),       m_dt2);
        check("model_done",   int'(o_ramp_done), m_done);
        check("duty_ceiling", int'(o_duty <= 8'(DMAX)), 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fault = 1'b0; ps = 1'b0; tgt = 8'd0; dt1 = 4'd0; dt2 = 4'd0;
        cycle();
        cycle();
        check("rst_state", int'(o_state), 0);
        check("rst_enable", int'(o_enable), 0);
        check("rst_duty", int'(o_duty), 0);
        check("rst_dt1", int'(o_dt1), 15);
        check("rst_dt2", int'(o_dt2), 15);
        check("rst_done", int'(o_ramp_done), 0);
        rst = 1'b0;
        cycle();

        // Soft start to duty 5
        en = 1'b1; tgt = 8'd5; dt1 = 4'd3; dt2 = 4'd4;
        cycle();
        check("t1_enable_latency", int'(o_enable), 1);
        check("t1_state_ramp", int'(o_state), 1);
        check("t1_dt1_load", int'(o_dt1), 3);
        repeat (4) cycle();
        check("t1_first_step", int'(o_duty), 1);
        repeat (16) cycle();
        check("t1_duty5", int'(o_duty), 5);
        check("t1_still_ramp", int'(o_state), 1);
        cycle();
        check("t1_run", int'(o_state), 2);
        check("t1_done", int'(o_ramp_done), 1);

        // Target changes in RUN are slewed
        tgt = 8'd2;
        repeat (12) cycle();
        check("t2_down_to_2", int'(o_duty), 2);
        tgt = 8'd255;
        repeat (240 * RDIV) cycle();
        check("t2_clamped", int'(o_duty), 242);
        repeat (8) cycle();
        check("t2_settled", int'(o_duty), 242);

        // Dead time only loads on period start
        dt1 = 4'd0; dt2 = 4'd9;
        repeat (20) cycle();
        check("t3_dt1_hold", int'(o_dt1), 3);
        check("t3_dt2_hold", int'(o_dt2), 4);
        ps = 1'b1;
        cycle();
        ps = 1'b0;
        check("t3_dt1_floor", int'(o_dt1), 2);
        check("t3_dt2_load", int'(o_dt2), 9);

        // Fault mid-ramp is latched until enable drops
        en = 1'b0;
        cycle();
        check("t4_idle", int'(o_state), 0);
        tgt = 8'd5; en = 1'b1;
        repeat (13) cycle();
        check("t4_duty3", int'(o_duty), 3);
        fault = 1'b1;
        cycle();
        fault = 1'b0;
        check("t4_fault_state", int'(o_state), 3);
        check("t4_fault_enable", int'(o_enable), 0);
        check("t4_fault_duty", int'(o_duty), 0);
        check("t4_fault_dt1", int'(o_dt1), 15);
        check("t4_fault_dt2", int'(o_dt2), 15);
        repeat (5) cycle();
        check("t4_fault_latched", int'(o_state), 3);
        en = 1'b0;
        cycle();
        check("t4_rearm_idle", int'(o_state), 0);
        en = 1'b1;
        cycle();
        check("t4_new_ramp_state", int'(o_state), 1);
        check("t4_new_ramp_duty", int'(o_duty), 0);

        // Fault and enable together in IDLE
        en = 1'b0;
        cycle();
        en = 1'b1; fault = 1'b1;
        cycle();
        fault = 1'b0;
        check("t5_fault_state", int'(o_state), 3);
        check("t5_no_enable", int'(o_enable), 0);
        repeat (4) begin
            cycle();
            check("t5_enable_low", int'(o_enable), 0);
        end
        en = 1'b0;
        cycle();
        check("t5_idle", int'(o_state), 0);

        // Reset in RUN, then zero-target start
        en = 1'b1; tgt = 8'd7;
        repeat (30) cycle();
        check("t6_run", int'(o_state), 2);
        check("t6_duty7", int'(o_duty), 7);
        rst = 1'b1;
        cycle();
        check("t6_rst_state", int'(o_state), 0);
        check("t6_rst_enable", int'(o_enable), 0);
        check("t6_rst_duty", int'(o_duty), 0);
        check("t6_rst_dt1", int'(o_dt1), 15);
        check("t6_rst_done", int'(o_ramp_done), 0);
        rst = 1'b0; tgt = 8'd0;
        cycle();
        check("t6_zero_ramp", int'(o_state), 1);
        check("t6_zero_enable", int'(o_enable), 1);
        cycle();
        check("t6_zero_run", int'(o_state), 2);
        check("t6_zero_duty", int'(o_duty), 0);
        check("t6_zero_enable_run", int'(o_enable), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 999) < 3);
            fault = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 63) == 0)
                tgt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                                   : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) begin
                dt1 = 4'($urandom);
                dt2 = 4'($urandom);
            end
            ps = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
